// File: rtl/rca_acc_pkg.sv
// rtl/rca_acc_pkg.sv - shared state encoding, default sizes and carry-extension width helper
package rca_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_COUNT_N = 16;

  // Summing COUNT_N carries needs log2(COUNT_N)+1 bits so the top can never wrap.
  function automatic int calc_hi_w(input int count_n);
    return $clog2(count_n) + 1;
  endfunction

endpackage

// File: rtl/rca_acc_frame_cnt.sv
// rtl/rca_acc_frame_cnt.sv - loadable frame up-counter with terminal-count flag at COUNT_N-1
module rca_acc_frame_cnt #(
  parameter int  COUNT_N = 16,
  localparam int CNT_W   = $clog2(COUNT_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority over increment; otherwise hold (bubbles leave the count alone).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(COUNT_N - 1));

endmodule

// File: rtl/rca_accumulator.sv
// rtl/rca_accumulator.sv - frame accumulator driving an external ripple-carry adder; RCA_ACC_CIN_EN adds per-operand carry-in
module rca_accumulator
  import rca_acc_pkg::*;
#(
  parameter int  WIDTH   = DEF_WIDTH,
  parameter int  COUNT_N = DEF_COUNT_N,
  localparam int HI_W    = calc_hi_w(COUNT_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
`ifdef RCA_ACC_CIN_EN
  input  logic                  in_cin,
`endif
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_s,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH+HI_W-1:0] out_sum,
  output logic                  busy
);

  localparam int CNT_W = $clog2(COUNT_N);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [HI_W-1:0]   acc_hi_q, acc_hi_d;
  logic              accept;
  logic              cnt_load;
  logic              cnt_tc;

  // Next-state and accumulator update; the adder result is only committed on an accept.
  always_comb begin
    state_d  = state_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    accept   = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_lo_d = '0;
          acc_hi_d = '0;
          cnt_load = 1'b1;
          state_d  = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          accept   = 1'b1;
          acc_lo_d = add_s;
          acc_hi_d = acc_hi_q + HI_W'(add_cout);
          if (cnt_tc) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and accumulator registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
    end
  end

  rca_acc_frame_cnt #(
    .COUNT_N (COUNT_N)
  ) u_frame_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val ({CNT_W{1'b0}}),
    .inc      (accept),
    .tc       (cnt_tc)
  );

  assign add_a = acc_lo_q;
  assign add_b = in_data;
`ifdef RCA_ACC_CIN_EN
  assign add_cin = (state_q == ACC) ? in_cin : 1'b0;
`else
  assign add_cin = 1'b0;
`endif

  // Status outputs decode straight from the state register so reset clears them at once.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_rca_accumulator.sv
// tb/tb_rca_accumulator.sv - randomized self-checking bench with behavioural frame-sum model
module tb_rca_accumulator;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int SW = 13;
`ifdef RCA_ACC_CIN_EN
  localparam bit CIN_ON = 1'b1;
`else
  localparam bit CIN_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_cin;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_s;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] frame_d [N];
  logic         frame_c [N];

  always #5 clk = ~clk;

  // External ripple-carry adder owned by the parent.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  rca_accumulator #(
    .WIDTH   (W),
    .COUNT_N (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef RCA_ACC_CIN_EN
    .in_cin    (in_cin),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the frame, integer running total, operands taken so far.
  int m_phase;
  int m_sum;
  int m_taken;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_sum   = 0;
      m_taken = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_sum   = 0;
        m_taken = 0;
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_sum   = m_sum + int'(in_data) + ((CIN_ON && in_cin) ? 1 : 0);
        m_taken = m_taken + 1;
        if (m_taken == N) m_phase = 2;
      end
    end else begin
      if (out_ready) m_phase = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", {31'd0, in_ready}, (m_phase == 1) ? 32'd1 : 32'd0);
      chk("out_valid", {31'd0, out_valid}, (m_phase == 2) ? 32'd1 : 32'd0);
      chk("busy", {31'd0, busy}, (m_phase != 0) ? 32'd1 : 32'd0);
      chk("out_sum", {19'd0, out_sum}, m_sum);
      chk("add_a", {24'd0, add_a}, m_sum % 256);
      chk("add_cin", {31'd0, add_cin}, (CIN_ON && m_phase == 1 && in_cin) ? 32'd1 : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int frame_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(frame_d[i]) + ((CIN_ON && frame_c[i]) ? 1 : 0);
    return s;
  endfunction

  task automatic send_frame(input int min_gap, input int max_gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      int gap;
      gap = (i > 0 && max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_cin   = 1'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = frame_d[i];
      in_cin   = frame_c[i];
      tick();
    end
    in_valid = 1'b0;
    in_cin   = 1'b0;
    chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic finish_frame(input int hold, input logic [SW-1:0] exp, input bit start_on_hs);
    for (int i = 0; i < hold; i++) begin
      chk("done_hold_sum", {19'd0, out_sum}, {19'd0, exp});
      chk("done_hold_in_ready", {31'd0, in_ready}, 32'd0);
      start    = i[0];
      in_valid = 1'b1;
      in_data  = W'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    chk("frame_sum", {19'd0, out_sum}, {19'd0, exp});
    out_ready = 1'b1;
    start     = start_on_hs;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("idle_after_hs_busy", {31'd0, busy}, 32'd0);
    chk("idle_after_hs_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("start_on_hs_ignored", {31'd0, busy}, 32'd0);
  endtask

  task automatic fill(input logic [W-1:0] d, input logic c);
    for (int i = 0; i < N; i++) begin
      frame_d[i] = d;
      frame_c[i] = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_out_sum", {19'd0, out_sum}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 16 x 01, no bubbles
    fill(8'h01, 1'b0);
    send_frame(0, 0);
    chk("ones_sum", {19'd0, out_sum}, 32'h0010);
    finish_frame(0, 13'h0010, 1'b0);

    // 16 x FF: carry out on all but the first accept
    fill(8'hFF, 1'b0);
    send_frame(0, 0);
    chk("ff_sum", {19'd0, out_sum}, 32'h0FF0);
    chk("ff_hi", {27'd0, out_sum[12:8]}, 32'd15);
    finish_frame(0, 13'h0FF0, 1'b0);

    // Same frame with 1-3 cycle bubbles, DONE held 5 cycles, start on the handshake
    send_frame(1, 3);
    chk("ff_gap_sum", {19'd0, out_sum}, 32'h0FF0);
    finish_frame(5, 13'h0FF0, 1'b1);

    // Reset mid-frame after 7 x 10
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h10;
    repeat (7) tick();
    in_valid = 1'b0;
    chk("partial_sum", {19'd0, out_sum}, 32'h0070);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sum", {19'd0, out_sum}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    fill(8'h02, 1'b0);
    send_frame(0, 0);
    chk("twos_sum", {19'd0, out_sum}, 32'h0020);
    finish_frame(1, 13'h0020, 1'b0);

    // Carry-in frame: counts only when the feature is built in
    fill(8'h00, 1'b1);
    send_frame(0, 2);
    chk("cin_sum", {19'd0, out_sum}, CIN_ON ? 32'h0010 : 32'h0000);
    finish_frame(0, CIN_ON ? 13'h0010 : 13'h0000, 1'b0);

    // Reset while DONE: out_valid drops at once
    fill(8'h05, 1'b0);
    send_frame(0, 0);
    rst = 1'b1;
    #1;
    chk("done_rst_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      int exp;
      for (int i = 0; i < N; i++) begin
        frame_d[i] = W'($urandom);
        frame_c[i] = 1'($urandom);
      end
      exp = frame_total();
      send_frame(0, 3);
      chk("rand_sum", {19'd0, out_sum}, exp);
      finish_frame(int'($urandom_range(4, 0)), SW'(exp), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
